// File: rtl/mem_wb_stage_skid.sv
// MEM/WB pipeline stage with valid/ready handshake and an optional 2-entry skid buffer.
// Also provides synchronous flush, an occupancy count and a saturating back-pressure stall counter.
module mem_wb_stage_skid #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int RD_W   = 5,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_memtoreg,
   input  logic              in_regwrite,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_memtoreg,
   output logic              out_regwrite,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = DATA_W + ADDR_W + RD_W + 2;

   logic [PW-1:0]    main_q, skid_q, main_d, skid_d, in_pl;
   logic             main_valid, skid_valid, main_valid_d, skid_valid_d;
   logic [1:0]       occ_q;
   logic [CNT_W-1:0] stall_q;
   logic             accept, drain;

   assign in_pl = {in_data, in_addr, in_rd, in_memtoreg, in_regwrite};

   // With the skid entry, in_ready depends only on a flop, cutting the path from out_ready.
   assign in_ready = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = main_valid && out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid;
      skid_valid_d = skid_valid;
      if (drain) begin
         if (skid_valid) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = in_pl;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_d       = in_pl;
            main_valid_d = 1'b1;
         end else if (SKID != 0) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
         end
      end
      if (clr) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         occ_q      <= 2'd0;
         stall_q    <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_valid <= main_valid_d;
         skid_valid <= skid_valid_d;
         occ_q      <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
         if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   // Payload is masked so a stale head can never look like a register write.
   assign {out_data, out_addr, out_rd, out_memtoreg, out_regwrite} = main_valid ? main_q : '0;
   assign out_valid = main_valid;
   assign occupancy = occ_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_wb_stage_skid.sv
// Bench for mem_wb_stage_skid: three instances (skid, skid with 4-bit counter, no skid)
// share one stimulus stream and are each checked against a queue-level reference model.
module tb_mem_wb_stage_skid;

   localparam int PW = 32 + 32 + 5 + 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic [31:0] in_addr = '0;
   logic [4:0]  in_rd = '0;
   logic        in_memtoreg = 1'b0;
   logic        in_regwrite = 1'b0;

   logic [2:0]        rdy, ov, om, orw;
   logic [2:0][31:0]  od, oa;
   logic [2:0][4:0]   ord;
   logic [2:0][1:0]   occ;
   logic [15:0]       st0, st2;
   logic [3:0]        st1;

   always #5 CLK = ~CLK;

   mem_wb_stage_skid #(.SKID(1), .CNT_W(16)) u_skid (
      .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd), .in_memtoreg(in_memtoreg),
      .in_regwrite(in_regwrite), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .out_addr(oa[0]), .out_rd(ord[0]), .out_memtoreg(om[0]), .out_regwrite(orw[0]),
      .occupancy(occ[0]), .stall_cnt(st0));

   mem_wb_stage_skid #(.SKID(1), .CNT_W(4)) u_sat (
      .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd), .in_memtoreg(in_memtoreg),
      .in_regwrite(in_regwrite), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .out_addr(oa[1]), .out_rd(ord[1]), .out_memtoreg(om[1]), .out_regwrite(orw[1]),
      .occupancy(occ[1]), .stall_cnt(st1));

   mem_wb_stage_skid #(.SKID(0), .CNT_W(16)) u_noskid (
      .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .in_addr(in_addr), .in_rd(in_rd), .in_memtoreg(in_memtoreg),
      .in_regwrite(in_regwrite), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
      .out_addr(oa[2]), .out_rd(ord[2]), .out_memtoreg(om[2]), .out_regwrite(orw[2]),
      .occupancy(occ[2]), .stall_cnt(st2));

   int tests = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: per instance, an ordered list of held beats and a stall count.
   logic [PW-1:0] m [3][2];
   int            cnt [3] = '{0, 0, 0};
   int            st  [3] = '{0, 0, 0};

   task automatic chk(input string nm, input int k, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got=%h exp=%h at %0t", nm, k, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      logic [PW-1:0] in_pl, got_pl, exp_pl;
      logic [15:0]   got_st;
      int            exp_st;
      bit            er, acc, drn;
      in_pl = {in_data, in_addr, in_rd, in_memtoreg, in_regwrite};
      for (int k = 0; k < 3; k++) begin
         er = (k == 2) ? (cnt[k] == 0 || out_ready) : (cnt[k] < 2);
         if (chk_en) begin
            got_pl = {od[k], oa[k], ord[k], om[k], orw[k]};
            exp_pl = (cnt[k] > 0) ? m[k][0] : '0;
            got_st = (k == 0) ? st0 : (k == 1) ? {12'd0, st1} : st2;
            exp_st = (k == 1) ? ((st[k] > 15) ? 15 : st[k]) : (st[k] & 16'hFFFF);
            chk("in_ready",  k, PW'(rdy[k]), PW'(er));
            chk("out_valid", k, PW'(ov[k]),  PW'(cnt[k] > 0));
            chk("occupancy", k, PW'(occ[k]), PW'(cnt[k]));
            chk("payload",   k, got_pl, exp_pl);
            chk("stall_cnt", k, PW'(got_st), PW'(exp_st));
         end
         if (RST) begin
            cnt[k] = 0;
            st[k]  = 0;
         end else begin
            if (cnt[k] > 0 && !out_ready) st[k]++;
            if (clr) begin
               cnt[k] = 0;
            end else begin
               drn = (cnt[k] > 0) && out_ready;
               acc = in_valid && er;
               if (drn) begin
                  m[k][0] = m[k][1];
                  cnt[k]--;
               end
               if (acc) begin
                  m[k][cnt[k]] = in_pl;
                  cnt[k]++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present one beat and hold it until the skid instance takes it.
   task automatic offer(input logic [31:0] d, input logic [4:0] rd);
      bit taken;
      taken = 1'b0;
      in_valid    = 1'b1;
      in_data     = d;
      in_rd       = rd;
      in_addr     = $urandom;
      in_memtoreg = 1'($urandom_range(0, 1));
      in_regwrite = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         @(negedge CLK);
         taken = in_valid && rdy[0];
         tick();
      end
      if (!taken) begin
         tests++;
         errors++;
         $display("FAIL offer_timeout got=not_accepted exp=accepted data=%h", d);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      RST    = 1'b0;
      chk_en = 1'b1;
      repeat (2) tick();

      // streaming
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) offer(32'h11 + 32'(i), 5'(i + 1));
      repeat (3) tick();

      // back-pressure
      out_ready = 1'b0;
      offer(32'hA0, 5'd10);
      offer(32'hA1, 5'd11);
      in_valid = 1'b1;
      in_data  = 32'hA2;
      in_rd    = 5'd12;
      repeat (3) tick();
      out_ready = 1'b1;
      offer(32'hA2, 5'd12);
      repeat (4) tick();

      // flush with a beat presented in the clr cycle
      out_ready = 1'b0;
      offer(32'hB0, 5'd13);
      offer(32'hB1, 5'd14);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hFF;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (3) tick();

      // stall counter saturation
      out_ready = 1'b0;
      offer(32'hC0, 5'd15);
      repeat (20) tick();
      chk("stall_sat", 1, PW'(st1), PW'(15));
      out_ready = 1'b1;
      repeat (3) tick();

      // no-skid in_ready follows out_ready combinationally
      out_ready = 1'b0;
      offer(32'hD0, 5'd16);
      in_valid = 1'b1;
      in_data  = 32'hD1;
      repeat (2) tick();
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      repeat (2) tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      // randomized traffic including flushes and resets
      for (int i = 0; i < 3000; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_data     = $urandom;
         in_addr     = $urandom;
         in_rd       = 5'($urandom_range(0, 31));
         in_memtoreg = 1'($urandom_range(0, 1));
         in_regwrite = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 2) != 0);
         clr         = ($urandom_range(0, 31) == 0);
         RST         = ($urandom_range(0, 255) == 0);
         tick();
      end
      RST       = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage_skid.md
Name: mem_wb_stage_skid

Overview:
- Parametrised successor of the MEM/WB pipeline register for the RISC-V core.
- Carries load/ALU result, address, destination register index and writeback controls from MEM to WB with a valid/ready handshake.
- Optional 2-entry skid buffer keeps in_ready registered while still sustaining full throughput.
- Adds synchronous flush, an occupancy output and a saturating back-pressure stall counter.

Parameters:
- DATA_W, 32, width of in_data/out_data.
- ADDR_W, 32, width of in_addr/out_addr.
- RD_W, 5, width of the destination register index.
- SKID, 1. 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- clr  in  1  synchronous flush of all held entries.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  memory/ALU result.
- in_addr  in  ADDR_W  ALU address.
- in_rd  in  RD_W  destination register index.
- in_memtoreg  in  1  WB select.
- in_regwrite  in  1  register-file write enable.
- out_valid  out  1  head entry valid.
- out_ready  in  1  WB consumes head.
- out_data  out  DATA_W  head payload.
- out_addr  out  ADDR_W  head payload.
- out_rd  out  RD_W  head payload.
- out_memtoreg  out  1  head payload.
- out_regwrite  out  1  head payload.
- occupancy  out  2  number of held entries, 0..2 (0..1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage: a main entry (head) and, when SKID=1, a skid entry. Each entry has its own valid bit.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready. Both evaluate on the same rising edge.
- SKID=1:
  - in_ready = !skid_valid. Registered; has no combinational path from out_ready.
  - Empty + accept: beat goes to main. out_valid=1 the next cycle (1-cycle latency).
  - Main full + drain + accept: new beat replaces main. Occupancy stays 1.
  - Main full + no drain + accept: beat goes to skid. Occupancy becomes 2 and in_ready=0 from the next cycle.
  - Full (2) + drain: skid moves to main, skid clears, in_ready=1 the next cycle. No accept is possible while full.
  - Ordering is strictly FIFO. A beat is never duplicated or dropped except by clr/RST.
- SKID=0:
  - in_ready = !main_valid || out_ready (combinational).
  - Main loads on accept; simultaneous drain + accept replaces main.
- out_valid = main_valid.
- All out_* payload signals read 0 whenever out_valid=0. out_regwrite is therefore never asserted without a valid beat.
- Hold: while out_valid && !out_ready, head payload is stable.
- clr:
  - Next cycle: both valid bits are 0, occupancy=0, payload outputs read 0, in_ready=1.
  - A beat presented in the same cycle as clr is discarded.
  - A drain in the same cycle as clr is still counted as consumed by WB. The stage applies no special action.
  - stall_cnt is not affected by clr.
- RST:
  - Priority is RST > clr > handshake.
  - Next cycle: entries invalid, occupancy=0, all payload outputs 0, stall_cnt=0.
  - in_ready=1 after reset (both modes).
  - Reset mid-stall discards all held beats.
- stall_cnt increments by 1 on every cycle with out_valid && !out_ready. It saturates at 2^CNT_W-1 and never wraps.
- occupancy = main_valid + skid_valid, registered, updated on the same edge as the entries.

Test Plan:
- Reset + idle: assert RST 2 cycles, release -> in_ready=1, out_valid=0, out_data=0, out_regwrite=0, occupancy=0, stall_cnt=0.
- Streaming (SKID=1), out_ready=1, beats data=0x11..0x18, rd=1..8 -> each appears 1 cycle later, in order, no bubbles; occupancy stays 1.
- Back-pressure (SKID=1):
  - Stimulus: out_ready=0 with beats 0xA0, 0xA1, 0xA2 offered.
  - Result: 0xA0 held in main, 0xA1 in skid, occupancy=2, in_ready=0, 0xA2 not accepted.
  - Then out_ready=1: outputs 0xA0, 0xA1, 0xA2 in order. stall_cnt equals the number of stalled cycles.
- Flush:
  - Stimulus: occupancy=2, assert clr together with in_valid (data 0xFF).
  - Result next cycle: out_valid=0, occupancy=0, in_ready=1, out_regwrite=0; 0xFF never appears.
  - stall_cnt is unchanged.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
- SKID=0 mode:
  - out_ready=0 with main full -> in_ready=0 in the same cycle.
  - Toggling out_ready=1 -> in_ready=1 in the same cycle. Simultaneous drain+accept replaces head; occupancy=1.
